// File: rtl/shot_resolver.sv
// shot_resolver
//
// Projectile engine and hit judge. When the block is idle and fire is high, it
// latches the target and the launch parameters. It then steps a ball up a 32x32
// playfield. The ball reflects off the side walls. On the step where the ball
// reaches the target row, the shot is judged and result_valid pulses for one
// enabled cycle.
//
// Optional feature macro: SHOT_HIT_WINDOW_EN
//   defined   : a hit is scored when |ball_x - tx| <= 1
//   undefined : a hit is scored only on an exact column match
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   ena          in   global enable; all state freezes while low
//   fire         in   launch request, sampled only in IDLE
//   start_x[4:0] in   launch column
//   dx_in[2:0]   in   signed horizontal step (-4 is clamped to -3)
//   target_x[4:0] in  target column
//   target_y[4:0] in  target row (0 means 32 steps)
//   ball_x[4:0]  out  current ball column
//   ball_y[4:0]  out  current ball row
//   busy         out  high in FLIGHT and RESULT
//   result_valid out  pulse when a shot is judged
//   hit          out  verdict of the last judged shot
//   hit_count[3:0] out number of hits, saturating at 15
//
// Parameter:
//   STEP_DIV     enabled clock cycles per ball step (1..16)
//
// State | meaning
// ------+---------------------------------------------
// IDLE  | waiting for fire; ball outputs hold last shot
// FLIGHT| ball stepping every STEP_DIV enabled cycles
// RESULT| result_valid high; next enabled edge -> IDLE

module shot_resolver #(
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       fire,
    input  logic [4:0] start_x,
    input  logic [2:0] dx_in,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic [4:0] ball_x,
    output logic [4:0] ball_y,
    output logic       busy,
    output logic       result_valid,
    output logic       hit,
    output logic [3:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

    state_t            state;
    logic [3:0]        div;
    logic [4:0]        tx;
    logic [4:0]        ty;
    logic signed [2:0] dx;

    logic signed [6:0] pos_ext;
    logic signed [6:0] dx_ext;
    logic signed [6:0] sum;
    logic signed [6:0] neg_sum;
    logic signed [6:0] far_sum;
    logic [4:0]        next_x;
    logic [4:0]        next_y;
    logic              reflect;
    logic              next_hit;
    logic [5:0]        diff;
    logic [5:0]        abs_diff;

    // -4 has no positive counterpart in 3 bits, so it is pulled in to -3
    function automatic logic signed [2:0] clamp_dx(input logic [2:0] raw);
        return (raw == 3'b100) ? 3'sb101 : $signed(raw);
    endfunction

    // One ball step with wall reflection, and the verdict it would produce
    always_comb begin
        pos_ext  = $signed({2'b00, ball_x});
        dx_ext   = {{4{dx[2]}}, dx};
        sum      = pos_ext + dx_ext;
        neg_sum  = -sum;
        far_sum  = 7'sd62 - sum;
        reflect  = 1'b0;
        next_x   = sum[4:0];
        if (sum < 7'sd0) begin
            next_x  = neg_sum[4:0];
            reflect = 1'b1;
        end else if (sum > 7'sd31) begin
            next_x  = far_sum[4:0];
            reflect = 1'b1;
        end
        // 5-bit row wraps, so ty == 0 matches after 32 steps
        next_y   = ball_y + 5'd1;
        diff     = {1'b0, next_x} - {1'b0, tx};
        abs_diff = diff[5] ? (6'd0 - diff) : diff;
`ifdef SHOT_HIT_WINDOW_EN
        next_hit = (abs_diff <= 6'd1);
`else
        next_hit = (abs_diff == 6'd0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div          <= 4'd0;
            tx           <= 5'd0;
            ty           <= 5'd0;
            dx           <= 3'sd0;
            ball_x       <= 5'd0;
            ball_y       <= 5'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            hit_count    <= 4'd0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (fire) begin
                        tx     <= target_x;
                        ty     <= target_y;
                        dx     <= clamp_dx(dx_in);
                        ball_x <= start_x;
                        ball_y <= 5'd0;
                        div    <= 4'd0;
                        busy   <= 1'b1;
                        state  <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (div == DIV_LAST) begin
                        div    <= 4'd0;
                        ball_x <= next_x;
                        ball_y <= next_y;
                        if (reflect) begin
                            dx <= -dx;
                        end
                        if (next_y == ty) begin
                            hit          <= next_hit;
                            result_valid <= 1'b1;
                            state        <= RESULT;
                            if (next_hit && hit_count != 4'd15) begin
                                hit_count <= hit_count + 4'd1;
                            end
                        end
                    end else begin
                        div <= div + 4'd1;
                    end
                end
                RESULT: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
// Testbench for shot_resolver.
// Shots come from a table of {launch, target, expected column, expected
// verdict} records. An entry is pushed to a scoreboard queue when a shot is
// fired. A monitor pops the entry and compares it when result_valid rises.
// Hand-written sequences cover these cases:
//   - back-to-back fire
//   - ena stalls
//   - reset in mid-flight
//   - hit_count saturation

module tb_shot_resolver;

    localparam int STEP_DIV = 4;
`ifdef SHOT_HIT_WINDOW_EN
    localparam logic WIN = 1'b1;
`else
    localparam logic WIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       fire;
    logic [4:0] start_x;
    logic [2:0] dx_in;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic [4:0] ball_x;
    logic [4:0] ball_y;
    logic       busy;
    logic       result_valid;
    logic       hit;
    logic [3:0] hit_count;

    shot_resolver #(.STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .reset(reset), .ena(ena), .fire(fire),
        .start_x(start_x), .dx_in(dx_in), .target_x(target_x), .target_y(target_y),
        .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .result_valid(result_valid),
        .hit(hit), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic ena_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        ena_at_edge <= ena;
    end

    typedef struct {
        int         e0;
        int         steps;
        int         extra;
        logic [4:0] x;
        logic [4:0] y;
        logic       h;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        logic [4:0] sx;
        logic [2:0] d;
        logic [4:0] tx;
        logic [4:0] ty;
        logic [4:0] ex;
        logic       eh;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_rv && ena_at_edge && !reset) begin
            check("rv_one_cycle", int'(result_valid), 0);
            check("busy_fall", int'(busy), 0);
        end
        if (result_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_result: result_valid with no shot pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.e0, e.steps * STEP_DIV + e.extra);
                check("ball_x", int'(ball_x), int'(e.x));
                check("ball_y", int'(ball_y), int'(e.y));
                check("hit", int'(hit), int'(e.h));
                check("hit_count", int'(hit_count), int'(e.cnt));
            end
        end
        prev_rv <= result_valid;
    end

    function automatic exp_t make_exp(input int e0, input logic [4:0] ty, input logic [4:0] ex,
                                      input logic eh, input int extra);
        exp_t e;
        e.e0    = e0;
        e.steps = (ty == 5'd0) ? 32 : int'(ty);
        e.extra = extra;
        e.x     = ex;
        e.y     = ty;
        e.h     = eh;
        if (eh && model_cnt != 15) model_cnt++;
        e.cnt   = 4'(model_cnt);
        return e;
    endfunction

    task automatic fire_shot(input logic [4:0] sx, input logic [2:0] d, input logic [4:0] tx,
                             input logic [4:0] ty, input logic [4:0] ex, input logic eh,
                             input int extra);
        @(negedge clk);
        start_x  = sx;
        dx_in    = d;
        target_x = tx;
        target_y = ty;
        fire     = 1'b1;
        sb.push_back(make_exp(cyc + 1, ty, ex, eh, extra));
        @(negedge clk);
        fire     = 1'b0;
        // Post-sample changes must be ignored
        target_x = ~tx;
        target_y = ~ty;
        start_x  = ~sx;
        dx_in    = ~d;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: shot not finished within %0d cycles", budget);
            sb.delete();
        end
    endtask

    vec_t vecs[10];
    int   rv_seen;
    int   n;
    int   e0;

    initial begin
        vecs[0] = '{5'd10, 3'd0, 5'd10, 5'd30, 5'd10, 1'b1};
        vecs[1] = '{5'd0,  3'd1, 5'd10, 5'd30, 5'd30, 1'b0};
        vecs[2] = '{5'd30, 3'd3, 5'd29, 5'd1,  5'd29, 1'b1};
        vecs[3] = '{5'd30, 3'd3, 5'd26, 5'd2,  5'd26, 1'b1};
        vecs[4] = '{5'd1,  3'b100, 5'd2, 5'd1, 5'd2,  1'b1};
        vecs[5] = '{5'd10, 3'd0, 5'd11, 5'd31, 5'd10, WIN};
        vecs[6] = '{5'd5,  3'd0, 5'd5,  5'd0,  5'd5,  1'b1};
        vecs[7] = '{5'd0,  3'd3, 5'd31, 5'd31, 5'd31, 1'b1};
        vecs[8] = '{5'd31, 3'b111, 5'd0, 5'd31, 5'd0, 1'b1};
        vecs[9] = '{5'd31, 3'b110, 5'd15, 5'd5, 5'd21, 1'b0};

        reset = 1'b1; ena = 1'b1; fire = 1'b0;
        start_x = 5'd0; dx_in = 3'd0; target_x = 5'd0; target_y = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_ball_x", int'(ball_x), 0);
        check("rst_ball_y", int'(ball_y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_count", int'(hit_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven shots
        for (int i = 0; i < 10; i++) begin
            fire_shot(vecs[i].sx, vecs[i].d, vecs[i].tx, vecs[i].ty, vecs[i].ex, vecs[i].eh, 0);
            wait_idle(300);
            @(negedge clk);
            check("idle_hold_x", int'(ball_x), int'(vecs[i].ex));
        end

        // Fire held high: ignored in flight, re-sampled one edge after returning to IDLE
        @(negedge clk);
        start_x = 5'd7; dx_in = 3'd0; target_x = 5'd7; target_y = 5'd1; fire = 1'b1;
        e0 = cyc + 1;
        sb.push_back(make_exp(e0, 5'd1, 5'd7, 1'b1, 0));
        sb.push_back(make_exp(e0 + STEP_DIV + 2, 5'd1, 5'd7, 1'b1, 0));
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        fire = 1'b0;
        check("b2b_done", int'(sb.size() == 0), 1);
        sb.delete();
        wait_idle(100);

        // ena stalls: freezes flight, stretches result_valid
        fire_shot(5'd10, 3'd1, 5'd12, 5'd2, 5'd12, 1'b1, 5);
        ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_y", int'(ball_y), 0);
            check("stall_busy", int'(busy), 1);
        end
        ena = 1'b1;
        n = 0;
        while (!result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_rv_seen", int'(result_valid), 1);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rv_stretch", int'(result_valid), 1);
            check("busy_stretch", int'(busy), 1);
        end
        ena = 1'b1;
        wait_idle(50);

        // Reset at step 15 aborts the shot
        @(negedge clk);
        start_x = 5'd10; dx_in = 3'd1; target_x = 5'd10; target_y = 5'd30; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        repeat (15 * STEP_DIV) @(negedge clk);
        check("pre_rst_y", int'(ball_y), 15);
        check("pre_rst_x", int'(ball_x), 25);
        #2 reset = 1'b1;
        #1;
        check("abort_x", int'(ball_x), 0);
        check("abort_y", int'(ball_y), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(hit_count), 0);
        check("abort_hit", int'(hit), 0);
        model_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (result_valid || busy) rv_seen++;
        end
        check("abort_no_result", rv_seen, 0);
        fire_shot(5'd10, 3'd0, 5'd10, 5'd30, 5'd10, 1'b1, 0);
        wait_idle(300);

        // Saturation: 16 more hits
        for (int i = 0; i < 16; i++) begin
            fire_shot(5'(i), 3'd0, 5'(i), 5'd1, 5'(i), 1'b1, 0);
            wait_idle(50);
        end
        check("saturate", int'(hit_count), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
